// File: rtl/dffrs_ctl.sv
// RN/SN/D driver for a DFFRS_X1 flop bank: synchronizes async set/clear requests into
// exclusive, minimum-width RN/SN pulses followed by a D-hold recovery window. The set path is built only when DFFRS_CTL_SET_EN is defined.
module dffrs_ctl #(
  parameter int SYNC_STAGES  = 2,
  parameter int PULSE_CYC    = 4,
  parameter int RECOVERY_CYC = 2,
  parameter int WIDTH        = 1
) (
  input  logic             CK,
  input  logic             R,
  input  logic             SET_REQ,
  input  logic             CLR_REQ,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D,
  output logic             RN,
  output logic             SN,
  output logic             BUSY
);

  localparam int MAX_CYC = (PULSE_CYC > RECOVERY_CYC) ? PULSE_CYC : RECOVERY_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVERY_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
`ifdef DFFRS_CTL_SET_EN
    ST_SET  = 2'd2,
`endif
    ST_REC  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               hold_q, hold_d;
  logic               rn_q, rn_d;
  logic               sn_q, sn_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   d_q, d_d;

  logic [SYNC_STAGES-1:0] clr_sync_q, clr_sync_d;
  logic                   clr_s;

  always_comb begin
    clr_sync_d = {clr_sync_q[SYNC_STAGES-2:0], CLR_REQ};
  end
  assign clr_s = clr_sync_q[SYNC_STAGES-1];

`ifdef DFFRS_CTL_SET_EN
  logic [SYNC_STAGES-1:0] set_sync_q, set_sync_d;
  logic                   set_s;

  always_comb begin
    set_sync_d = {set_sync_q[SYNC_STAGES-2:0], SET_REQ};
  end
  assign set_s = set_sync_q[SYNC_STAGES-1];

  always_ff @(posedge CK or posedge R) begin
    if (R) set_sync_q <= '0;
    else   set_sync_q <= set_sync_d;
  end
`else
  logic unused_set_req;
  assign unused_set_req = SET_REQ;
`endif

  // Next state; the counter restarts whenever the state changes and saturates otherwise.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (clr_s) state_d = ST_CLR;
`ifdef DFFRS_CTL_SET_EN
        else if (set_s) state_d = ST_SET;
`endif
      end
      ST_CLR: begin
        if (cnt_q >= PULSE_LAST && !clr_s) begin
          state_d = ST_REC;
          hold_d  = 1'b0;
        end
      end
`ifdef DFFRS_CTL_SET_EN
      ST_SET: begin
        // A clear only cuts a set short once the set has met its minimum width.
        if (cnt_q >= PULSE_LAST && (!set_s || clr_s)) begin
          state_d = ST_REC;
          hold_d  = 1'b1;
        end
      end
`endif
      ST_REC: begin
        if (clr_s) state_d = ST_CLR;
`ifdef DFFRS_CTL_SET_EN
        else if (set_s) state_d = ST_SET;
`endif
        else if (cnt_q >= REC_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_CLR;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so the pins change on the same edge as the state.
  always_comb begin
    rn_d   = 1'b1;
    sn_d   = 1'b1;
    busy_d = 1'b1;
    d_d    = D_IN;
    case (state_d)
      ST_IDLE: busy_d = 1'b0;
      ST_CLR: begin
        rn_d = 1'b0;
        d_d  = '0;
      end
`ifdef DFFRS_CTL_SET_EN
      ST_SET: begin
        sn_d = 1'b0;
        d_d  = '1;
      end
`endif
      ST_REC:  d_d = {WIDTH{hold_d}};
      default: begin
        rn_d = 1'b0;
        d_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CK or posedge R) begin
    if (R) begin
      state_q    <= ST_CLR;
      cnt_q      <= '0;
      hold_q     <= 1'b0;
      rn_q       <= 1'b0;
      sn_q       <= 1'b1;
      busy_q     <= 1'b1;
      d_q        <= '0;
      clr_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      rn_q       <= rn_d;
      sn_q       <= sn_d;
      busy_q     <= busy_d;
      d_q        <= d_d;
      clr_sync_q <= clr_sync_d;
    end
  end

  assign RN   = rn_q;
  assign SN   = sn_q;
  assign BUSY = busy_q;
  assign D    = d_q;

endmodule

// File: tb/tb_dffrs_ctl.sv
// Scoreboard bench for dffrs_ctl: stimulus queues per-cycle pin expectations, a negedge monitor pops and compares.
module tb_dffrs_ctl;

  logic       CK = 1'b0;
  logic       R;
  logic       SET_REQ;
  logic       CLR_REQ;
  logic [0:0] D_IN;
  logic [0:0] D;
  logic       RN;
  logic       SN;
  logic       BUSY;

  dffrs_ctl #(
    .SYNC_STAGES (2),
    .PULSE_CYC   (4),
    .RECOVERY_CYC(2),
    .WIDTH       (1)
  ) dut (
    .CK     (CK),
    .R      (R),
    .SET_REQ(SET_REQ),
    .CLR_REQ(CLR_REQ),
    .D_IN   (D_IN),
    .D      (D),
    .RN     (RN),
    .SN     (SN),
    .BUSY   (BUSY)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pins;   // {RN, SN, D, BUSY}
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Pin patterns {RN,SN,D,BUSY}
  localparam logic [3:0] P_CLR   = 4'b0101;
  localparam logic [3:0] P_SET   = 4'b1011;
  localparam logic [3:0] P_REC0  = 4'b1101;
  localparam logic [3:0] P_REC1  = 4'b1111;
  localparam logic [3:0] P_IDLE0 = 4'b1100;
  localparam logic [3:0] P_IDLE1 = 4'b1110;

  task automatic push_rng(input int from, input int to, input logic [3:0] pins, input string tag);
    for (int i = from; i <= to; i++) begin
      exp_t e;
      e.cyc  = i;
      e.pins = pins;
      e.tag  = tag;
      sb.push_back(e);
    end
  endtask

  task automatic check_now(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got RN,SN,D,BUSY=%b expected %b", tag, got, exp);
    end
  endtask

  always @(negedge CK) begin
    checks++;
    if (RN === 1'b0 && SN === 1'b0) begin
      errors++;
      $display("FAIL excl cyc %0d: got RN=0 SN=0 expected not both low", cyc);
    end
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.tag, e.cyc, cyc);
      end else if ({RN, SN, D[0], BUSY} !== e.pins) begin
        errors++;
        $display("FAIL %s cyc %0d: got RN,SN,D,BUSY=%b expected %b", e.tag, cyc,
                 {RN, SN, D[0], BUSY}, e.pins);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) begin
      @(negedge CK);
      #1;
    end
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] pat;

    R = 1'b1; SET_REQ = 1'b0; CLR_REQ = 1'b0; D_IN = 1'b1;
    #1;
    check_now("reset_async", {RN, SN, D[0], BUSY}, P_CLR);

    // Reset held 3 cycles, then the normal CLR exit.
    repeat (3) @(negedge CK);
    c = cyc;
    push_rng(c + 1, c + 3, P_CLR,   "rst_rn_low");
    push_rng(c + 4, c + 5, P_REC0,  "rst_rec");
    push_rng(c + 6, c + 6, P_IDLE1, "rst_idle");
    R = 1'b0;
    drain();

    // One-cycle clear request.
    @(negedge CK);
    c = cyc;
    D_IN = 1'b1; CLR_REQ = 1'b1;
    push_rng(c + 1, c + 2, P_IDLE1, "clr_latency");
    push_rng(c + 3, c + 6, P_CLR,   "clr_pulse");
    push_rng(c + 7, c + 8, P_REC0,  "clr_rec");
    push_rng(c + 9, c + 9, P_IDLE1, "clr_idle");
    @(negedge CK);
    CLR_REQ = 1'b0;
    drain();

    // Ten-cycle set request.
    @(negedge CK);
    c = cyc;
    D_IN = 1'b0; SET_REQ = 1'b1;
`ifdef DFFRS_CTL_SET_EN
    push_rng(c + 1,  c + 2,  P_IDLE0, "set_latency");
    push_rng(c + 3,  c + 12, P_SET,   "set_pulse");
    push_rng(c + 13, c + 14, P_REC1,  "set_rec");
    push_rng(c + 15, c + 15, P_IDLE0, "set_idle");
`else
    push_rng(c + 1,  c + 15, P_IDLE0, "set_ignored");
`endif
    repeat (10) @(negedge CK);
    SET_REQ = 1'b0;
    drain();

    // Set and clear rise together: clear wins.
    @(negedge CK);
    c = cyc;
    D_IN = 1'b1; SET_REQ = 1'b1; CLR_REQ = 1'b1;
    push_rng(c + 1, c + 2, P_IDLE1, "both_latency");
    push_rng(c + 3, c + 6, P_CLR,   "both_clr");
    push_rng(c + 7, c + 8, P_REC0,  "both_rec");
    push_rng(c + 9, c + 9, P_IDLE1, "both_idle");
    repeat (2) @(negedge CK);
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    drain();

`ifdef DFFRS_CTL_SET_EN
    // Clear arrives mid-set: set finishes its minimum width, one REC cycle, then clear.
    @(negedge CK);
    c = cyc;
    D_IN = 1'b1; SET_REQ = 1'b1;
    push_rng(c + 1,  c + 2,  P_IDLE1, "mid_latency");
    push_rng(c + 3,  c + 6,  P_SET,   "mid_set");
    push_rng(c + 7,  c + 7,  P_REC1,  "mid_gap");
    push_rng(c + 8,  c + 11, P_CLR,   "mid_clr");
    push_rng(c + 12, c + 13, P_REC0,  "mid_rec");
    push_rng(c + 14, c + 14, P_IDLE1, "mid_idle");
    @(negedge CK);
    CLR_REQ = 1'b1;
    repeat (7) @(negedge CK);
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    drain();
`endif

    // Reset pulsed while a set request is in flight.
    @(negedge CK);
    c = cyc;
    D_IN = 1'b1; SET_REQ = 1'b1;
    push_rng(c + 1, c + 2, P_IDLE1, "rmid_latency");
`ifdef DFFRS_CTL_SET_EN
    push_rng(c + 3, c + 4, P_SET,   "rmid_set");
`else
    push_rng(c + 3, c + 4, P_IDLE1, "rmid_noset");
`endif
    repeat (4) @(negedge CK);
    #2;
    R = 1'b1;
    SET_REQ = 1'b0;
    #1;
    check_now("rmid_async", {RN, SN, D[0], BUSY}, P_CLR);
    push_rng(c + 5, c + 5, P_CLR, "rmid_held");
    @(negedge CK);
    c = cyc;
    push_rng(c + 1, c + 3, P_CLR,   "rmid_rn_low");
    push_rng(c + 4, c + 5, P_REC0,  "rmid_rec");
    push_rng(c + 6, c + 6, P_IDLE1, "rmid_idle");
    R = 1'b0;
    drain();

    // IDLE data path: D follows D_IN one cycle later.
    pat = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      @(negedge CK);
      D_IN = pat[i];
      push_rng(cyc + 1, cyc + 1, pat[i] ? P_IDLE1 : P_IDLE0, "idle_data");
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
